// File: rtl/fetch_unit_if.sv
// Fetch-unit bus bundle: PC register hookup, instruction ROM port, control inputs, downstream stream.
// The master modport is the fetch unit; the slave modport is the surrounding core and testbench.
interface fetch_unit_if;
   logic [11:0] pc_in;
   logic [11:0] pc_next;
   logic        pc_we;
   logic [11:0] imem_addr;
   logic [31:0] imem_q;
   logic        redirect_valid;
   logic [11:0] redirect_target;
   logic        halt_req;
   logic        fd_valid;
   logic        fd_ready;
   logic [11:0] fd_pc;
   logic [31:0] fd_insn;

   modport master (
      input  pc_in, imem_q, redirect_valid, redirect_target, halt_req, fd_ready,
      output pc_next, pc_we, imem_addr, fd_valid, fd_pc, fd_insn
   );

   modport slave (
      output pc_in, imem_q, redirect_valid, redirect_target, halt_req, fd_ready,
      input  pc_next, pc_we, imem_addr, fd_valid, fd_pc, fd_insn
   );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch with a QDEPTH-entry queue; an entry is visible on fd_* 2 cycles after its issue.
// Backpressure: issue only while queued + in-flight entries fit, so a stalled fd_ready never overflows.
module fetch_unit #(
   parameter int QDEPTH = 2
) (
   input  logic         clock,
   input  logic         ctrl_reset,
   fetch_unit_if.master bus
);
   localparam int AW = $clog2(QDEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW:0] OCC_LIM = QDEPTH[CW:0];

   typedef enum logic {
      ST_ACTIVE = 1'b0,
      ST_HALTED = 1'b1
   } state_t;

   state_t        r_state;
   state_t        w_state_nxt;
   logic [CW-1:0] r_count;
   logic [CW-1:0] w_count_nxt;
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic          r_infl;
   logic [11:0]   r_infl_pc;
   logic [11:0]   r_q_pc   [QDEPTH];
   logic [31:0]   r_q_insn [QDEPTH];

   logic          w_pop;
   logic          w_enq;
   logic          w_issue;
   logic          w_room;
   logic          w_redirect;
   logic [CW:0]   w_occ;

   assign bus.imem_addr = bus.pc_in;

   assign bus.fd_valid = (r_count != '0);
   assign w_pop        = bus.fd_valid & bus.fd_ready;
   // A redirect in the cycle the ROM data lands throws that data away with the rest of the queue.
   assign w_enq        = r_infl & ~bus.redirect_valid;

   assign w_occ  = {1'b0, r_count} + {{CW{1'b0}}, r_infl} - {{CW{1'b0}}, w_pop};
   assign w_room = (w_occ < OCC_LIM);

   assign w_redirect = bus.redirect_valid & ~ctrl_reset;
   assign w_issue    = ~ctrl_reset & (r_state == ST_ACTIVE) & ~bus.halt_req
                     & ~bus.redirect_valid & w_room;

   assign bus.pc_we   = w_issue | w_redirect;
   assign bus.pc_next = bus.redirect_valid ? bus.redirect_target : bus.pc_in + 12'd1;

   assign bus.fd_pc   = bus.fd_valid ? r_q_pc[r_rd_ptr]   : 12'd0;
   assign bus.fd_insn = bus.fd_valid ? r_q_insn[r_rd_ptr] : 32'd0;

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_ACTIVE: if (bus.halt_req && !bus.redirect_valid) w_state_nxt = ST_HALTED;
         ST_HALTED: if (bus.redirect_valid) w_state_nxt = ST_ACTIVE;
         default:   w_state_nxt = ST_ACTIVE;
      endcase
   end

   always_comb begin
      w_count_nxt = r_count;
      if (bus.redirect_valid) begin
         w_count_nxt = '0;
      end else begin
         w_count_nxt = r_count + {{AW{1'b0}}, w_enq} - {{AW{1'b0}}, w_pop};
      end
   end

   always_ff @(posedge clock or posedge ctrl_reset) begin
      if (ctrl_reset) begin
         r_state   <= ST_ACTIVE;
         r_count   <= '0;
         r_wr_ptr  <= '0;
         r_rd_ptr  <= '0;
         r_infl    <= 1'b0;
         r_infl_pc <= 12'd0;
      end else begin
         r_state <= w_state_nxt;
         r_count <= w_count_nxt;
         r_infl  <= w_issue;
         if (w_issue) r_infl_pc <= bus.pc_in;
         if (bus.redirect_valid) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
         end else begin
            if (w_enq) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
         end
      end
   end

   always_ff @(posedge clock) begin
      if (w_enq) begin
         r_q_pc[r_wr_ptr]   <= r_infl_pc;
         r_q_insn[r_wr_ptr] <= bus.imem_q;
      end
   end
endmodule

// File: tb/tb_fetch_unit.sv
// Directed and random checks of fetch_unit against an in-order delivered-PC model.
module tb_fetch_unit;
   logic clock;
   logic ctrl_reset;

   fetch_unit_if bus ();

   fetch_unit #(.QDEPTH(2)) dut (
      .clock      (clock),
      .ctrl_reset (ctrl_reset),
      .bus        (bus)
   );

   int          n_checks;
   int          n_err;
   int          n_hs;
   logic [11:0] exp_pc;
   bit          m_halted;
   int unsigned rom_salt;

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   function automatic logic [31:0] rom_f(input logic [11:0] a);
      return 32'(a) + 32'd100 + rom_salt;
   endfunction

   // PC register and synchronous ROM surrounding the fetch unit
   always_ff @(posedge clock or posedge ctrl_reset) begin
      if (ctrl_reset) bus.pc_in <= 12'd0;
      else if (bus.pc_we) bus.pc_in <= bus.pc_next;
   end

   always_ff @(posedge clock) bus.imem_q <= rom_f(bus.imem_addr);

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock cycle with the inputs already driven; checks and model update happen before the edge.
   task automatic cyc();
      #1;
      chk("imem_addr", 32'(bus.imem_addr), 32'(bus.pc_in));
      if (bus.redirect_valid) begin
         chk("redir_we", 32'(bus.pc_we), 32'd1);
         chk("redir_next", 32'(bus.pc_next), 32'(bus.redirect_target));
      end else if (m_halted || bus.halt_req) begin
         chk("halt_we", 32'(bus.pc_we), 32'd0);
      end
      if (bus.fd_valid && bus.fd_ready) begin
         chk("hs_pc", 32'(bus.fd_pc), 32'(exp_pc));
         chk("hs_insn", bus.fd_insn, rom_f(exp_pc));
         exp_pc = exp_pc + 12'd1;
         n_hs++;
      end
      if (bus.redirect_valid) begin
         exp_pc   = bus.redirect_target;
         m_halted = 1'b0;
      end else if (bus.halt_req) begin
         m_halted = 1'b1;
      end
      @(posedge clock);
      @(negedge clock);
   endtask

   task automatic run_stream(input string tag, input int n, input int bound);
      int start;
      int cycles;
      start  = n_hs;
      cycles = 0;
      while ((n_hs - start) < n && cycles < bound) begin
         cyc();
         cycles++;
      end
      chk(tag, 32'(n_hs - start), 32'(n));
   endtask

   task automatic do_reset();
      ctrl_reset          = 1'b1;
      bus.redirect_valid  = 1'b0;
      bus.halt_req        = 1'b0;
      @(negedge clock);
      @(negedge clock);
      ctrl_reset = 1'b0;
      exp_pc     = 12'd0;
      m_halted   = 1'b0;
   endtask

   initial begin
      int          hs0;
      n_checks = 0;
      n_err    = 0;
      n_hs     = 0;
      exp_pc   = 12'd0;
      m_halted = 1'b0;
      rom_salt = 0;
      ctrl_reset          = 1'b1;
      bus.fd_ready        = 1'b1;
      bus.halt_req        = 1'b0;
      bus.redirect_valid  = 1'b0;
      bus.redirect_target = 12'd0;

      // Reset values
      repeat (3) @(negedge clock);
      #1;
      chk("rst_vld", 32'(bus.fd_valid), 32'd0);
      chk("rst_pc", 32'(bus.fd_pc), 32'd0);
      chk("rst_insn", bus.fd_insn, 32'd0);
      chk("rst_we", 32'(bus.pc_we), 32'd0);

      // First fetch after release; delivery starts exactly two cycles later, then one per cycle
      @(negedge clock);
      ctrl_reset = 1'b0;
      #1;
      chk("first_we", 32'(bus.pc_we), 32'd1);
      chk("first_next", 32'(bus.pc_next), 32'd1);
      chk("first_vld0", 32'(bus.fd_valid), 32'd0);
      cyc();
      #1;
      chk("first_vld1", 32'(bus.fd_valid), 32'd0);
      cyc();
      #1;
      chk("first_pc", 32'(bus.fd_pc), 32'd0);
      chk("first_insn", bus.fd_insn, 32'd100);
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("stream_vld", 32'(bus.fd_valid), 32'd1);
         cyc();
      end
      chk("stream_cnt", 32'(n_hs), 32'd4);

      // Backpressure from the start: queue fills with pc 0,1 and the PC stops at 2
      do_reset();
      bus.fd_ready = 1'b0;
      repeat (4) cyc();
      #1;
      chk("bp_pc_in", 32'(bus.pc_in), 32'd2);
      chk("bp_vld", 32'(bus.fd_valid), 32'd1);
      chk("bp_head", 32'(bus.fd_pc), 32'd0);
      cyc();
      bus.fd_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("bp_drain_vld", 32'(bus.fd_valid), 32'd1);
         cyc();
      end
      chk("bp_drain_pc", 32'(exp_pc), 32'd4);

      // Redirect with a full queue flushes it
      do_reset();
      bus.fd_ready = 1'b0;
      repeat (3) cyc();
      #1;
      chk("full_vld", 32'(bus.fd_valid), 32'd1);
      bus.redirect_valid  = 1'b1;
      bus.redirect_target = 12'h040;
      cyc();
      bus.redirect_valid = 1'b0;
      #1;
      chk("flush_vld", 32'(bus.fd_valid), 32'd0);
      bus.fd_ready = 1'b1;
      run_stream("redir_040", 3, 10);

      // PC wrap-around at the top of the address space
      bus.redirect_valid  = 1'b1;
      bus.redirect_target = 12'hFFF;
      cyc();
      bus.redirect_valid = 1'b0;
      #1;
      chk("wrap_pc_in", 32'(bus.pc_in), 32'hFFF);
      chk("wrap_we", 32'(bus.pc_we), 32'd1);
      chk("wrap_next", 32'(bus.pc_next), 32'd0);
      run_stream("wrap", 3, 10);

      // Halt in steady state: head plus the in-flight fetch still arrive, then nothing
      run_stream("pre_halt", 2, 10);
      bus.halt_req = 1'b1;
      hs0 = n_hs;
      cyc();
      bus.halt_req = 1'b0;
      repeat (6) cyc();
      chk("halt_drain", 32'(n_hs - hs0), 32'd2);
      #1;
      chk("halt_vld", 32'(bus.fd_valid), 32'd0);
      bus.redirect_valid  = 1'b1;
      bus.redirect_target = 12'h010;
      cyc();
      bus.redirect_valid = 1'b0;
      run_stream("resume_010", 3, 10);

      // Reset mid-stream with a full queue
      bus.fd_ready = 1'b0;
      repeat (3) cyc();
      #1;
      chk("pre_rst_vld", 32'(bus.fd_valid), 32'd1);
      ctrl_reset = 1'b1;
      #1;
      chk("mid_rst_vld", 32'(bus.fd_valid), 32'd0);
      chk("mid_rst_pc", 32'(bus.fd_pc), 32'd0);
      chk("mid_rst_insn", bus.fd_insn, 32'd0);
      chk("mid_rst_we", 32'(bus.pc_we), 32'd0);
      exp_pc   = 12'd0;
      m_halted = 1'b0;
      @(negedge clock);
      @(negedge clock);
      ctrl_reset   = 1'b0;
      bus.fd_ready = 1'b1;
      run_stream("restart", 3, 10);

      // Random backpressure, redirects and halts over fresh ROM contents
      ctrl_reset = 1'b1;
      rom_salt   = $urandom;
      do_reset();
      for (int i = 0; i < 800; i++) begin
         bus.fd_ready        = ($urandom_range(0, 9) < 7);
         bus.redirect_valid  = ($urandom_range(0, 99) < 5);
         bus.redirect_target = 12'($urandom);
         bus.halt_req        = ($urandom_range(0, 99) < 4);
         cyc();
      end
      bus.redirect_valid  = 1'b1;
      bus.redirect_target = 12'hFFE;
      bus.halt_req        = 1'b0;
      bus.fd_ready        = 1'b1;
      cyc();
      bus.redirect_valid = 1'b0;
      run_stream("rand_tail", 4, 12);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
      $finish;
   end
endmodule
